// File: rtl/aes_key_expand_rev_pkg.sv
// Shared constants and helpers for the reverse AES-128 key schedule.
package aes_key_expand_rev_pkg;

  localparam int unsigned AES_NR = 10;

  // FSM encodings
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StFwd  = 2'd1;
  localparam logic [1:0] StRev  = 2'd2;

  // Forward S-box, byte 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte b sits at bit offset (255 - b) * 8, and (255 - b) == ~b for a byte.
  function automatic logic [7:0] sbox_byte(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  // Round constant for rounds 1..10; zero elsewhere.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_expand_rev_sub_word.sv
// Combinational SubWord: four parallel S-box lookups.
module aes_key_expand_rev_sub_word
  import aes_key_expand_rev_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub
);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign sub[8*i +: 8] = sbox_byte(word[8*i +: 8]);
  end

endmodule

// File: rtl/aes_key_expand_rev.sv
// Sequential AES-128 reverse key schedule: runs the schedule forward to round key 10, then
// streams round keys 10..0 over valid/ready, caching round key 10 for later replays.
module aes_key_expand_rev
  import aes_key_expand_rev_pkg::*;
#(
  parameter int unsigned KEY_IS_LAST = 0,
  parameter int unsigned OUT_REG     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic         replay,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         rk_last,
  output logic         busy,
  output logic         cache_vld
);

  // Only the registered-output variant exists.
  if (OUT_REG != 1) begin : g_bad_out_reg
    $error("aes_key_expand_rev: OUT_REG must be 1");
  end

  localparam logic [3:0] RND_LAST = 4'(AES_NR);

  logic [1:0]   state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] cache_q, cache_d;
  logic         cache_vld_q, cache_vld_d;
  logic [3:0]   rnd_q, rnd_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sw_in, sw_out;
  logic [7:0]   rc;
  logic [127:0] fwd_key, inv_key;
  logic         is_rev;

  assign w0 = st_q[127:96];
  assign w1 = st_q[95:64];
  assign w2 = st_q[63:32];
  assign w3 = st_q[31:0];

  assign is_rev = (state_q == StRev);

  // Forward needs SubWord(RotWord(w3)); reverse recovers the previous w3 as w3^w2 first.
  always_comb begin
    sw_in = rot_word(is_rev ? (w3 ^ w2) : w3);
    rc    = is_rev ? rcon(rnd_q) : rcon(rnd_q + 4'd1);
  end

  aes_key_expand_rev_sub_word u_sub_word (
    .word (sw_in),
    .sub  (sw_out)
  );

  // One forward and one inverse schedule step, both fed by the shared SubWord.
  always_comb begin
    logic [31:0] n0, n1, n2, n3;
    logic [31:0] p0, p1, p2, p3;
    n0 = w0 ^ sw_out ^ {rc, 24'h0};
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    p0 = w0 ^ sw_out ^ {rc, 24'h0};
    fwd_key = {n0, n1, n2, n3};
    inv_key = {p0, p1, p2, p3};
  end

  // Next-state logic for the FSM and datapath registers.
  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    cache_d     = cache_q;
    cache_vld_d = cache_vld_q;
    rnd_d       = rnd_q;
    case (state_q)
      StIdle: begin
        if (key_valid) begin
          st_d        = key_in;
          cache_vld_d = 1'b0;
          if (KEY_IS_LAST != 0) begin
            // Loaded key already is round key 10, so it doubles as the cache entry.
            rnd_d       = RND_LAST;
            cache_d     = key_in;
            cache_vld_d = 1'b1;
            state_d     = StRev;
          end else begin
            rnd_d   = 4'd0;
            state_d = StFwd;
          end
        end else if (replay && cache_vld_q) begin
          st_d    = cache_q;
          rnd_d   = RND_LAST;
          state_d = StRev;
        end
      end
      StFwd: begin
        if (rnd_q == RND_LAST) begin
          cache_d     = st_q;
          cache_vld_d = 1'b1;
          state_d     = StRev;
        end else begin
          st_d  = fwd_key;
          rnd_d = rnd_q + 4'd1;
        end
      end
      StRev: begin
        if (rk_ready) begin
          if (rnd_q == 4'd0) begin
            state_d = StIdle;
          end else begin
            st_d  = inv_key;
            rnd_d = rnd_q - 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      st_q        <= '0;
      cache_q     <= '0;
      cache_vld_q <= 1'b0;
      rnd_q       <= '0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      cache_q     <= cache_d;
      cache_vld_q <= cache_vld_d;
      rnd_q       <= rnd_d;
    end
  end

  assign key_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign rk_valid  = is_rev;
  assign rk_out    = st_q;
  assign rk_round  = rnd_q;
  assign rk_last   = is_rev && (rnd_q == 4'd0);
  assign cache_vld = cache_vld_q;

endmodule

// File: tb/tb_aes_key_expand_rev.sv
// Scoreboard bench for aes_key_expand_rev using the FIPS-197 appendix A.1 key schedule.
module tb_aes_key_expand_rev;

  typedef struct {
    logic [127:0] rk;
    logic [3:0]   rnd;
  } exp_t;

  // FIPS-197 A.1 round keys 0..10 for key 2b7e1516...
  localparam logic [127:0] RK_TAB [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic         replay = 1'b0;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready = 1'b1;
  logic         rk_last;
  logic         busy;
  logic         cache_vld;

  logic [127:0] key_in2 = '0;
  logic         key_valid2 = 1'b0;
  logic         key_ready2;
  logic         replay2 = 1'b0;
  logic [127:0] rk_out2;
  logic [3:0]   rk_round2;
  logic         rk_valid2;
  logic         rk_ready2 = 1'b1;
  logic         rk_last2;
  logic         busy2;
  logic         cache_vld2;

  int  vectors = 0;
  int  miscompares = 0;
  bit  rand_ready = 1'b0;
  exp_t q1[$];
  exp_t q2[$];

  aes_key_expand_rev #(.KEY_IS_LAST(0), .OUT_REG(1)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .replay(replay), .rk_out(rk_out), .rk_round(rk_round), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .rk_last(rk_last), .busy(busy), .cache_vld(cache_vld)
  );

  aes_key_expand_rev #(.KEY_IS_LAST(1), .OUT_REG(1)) dut_last (
    .clk(clk), .rst(rst), .key_in(key_in2), .key_valid(key_valid2), .key_ready(key_ready2),
    .replay(replay2), .rk_out(rk_out2), .rk_round(rk_round2), .rk_valid(rk_valid2),
    .rk_ready(rk_ready2), .rk_last(rk_last2), .busy(busy2), .cache_vld(cache_vld2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_stream1();
    for (int r = 10; r >= 0; r--) q1.push_back('{rk: RK_TAB[r], rnd: 4'(r)});
  endtask

  task automatic push_stream2();
    for (int r = 10; r >= 0; r--) q2.push_back('{rk: RK_TAB[r], rnd: 4'(r)});
  endtask

  // Monitor for the default instance: compare every presented beat, pop on acceptance.
  always @(negedge clk) begin
    if (!rst && rk_valid) begin
      if (q1.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL mon_unexpected: got round %0d key %h, expected no beat", rk_round, rk_out);
      end else begin
        check("mon_rk", rk_out, q1[0].rk);
        check("mon_round", 128'(rk_round), 128'(q1[0].rnd));
        check("mon_last", 128'(rk_last), 128'(q1[0].rnd == 4'd0));
        if (rk_ready) void'(q1.pop_front());
      end
    end
  end

  // Monitor for the KEY_IS_LAST instance.
  always @(negedge clk) begin
    if (!rst && rk_valid2) begin
      if (q2.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL mon2_unexpected: got round %0d key %h, expected no beat", rk_round2,
                 rk_out2);
      end else begin
        check("mon2_rk", rk_out2, q2[0].rk);
        check("mon2_round", 128'(rk_round2), 128'(q2[0].rnd));
        check("mon2_last", 128'(rk_last2), 128'(q2[0].rnd == 4'd0));
        if (rk_ready2) void'(q2.pop_front());
      end
    end
  end

  // Random back-pressure, driven off the sampling edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) rk_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in    = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic pulse_replay();
    replay = 1'b1;
    tick();
    replay = 1'b0;
  endtask

  // Cycles from the current point until rk_valid shows up.
  task automatic measure_latency(output int n);
    n = 0;
    while (!rk_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle(input string name, input int limit);
    for (int i = 0; i < limit && busy; i++) tick();
    check(name, 128'(busy), 128'(0));
  endtask

  task automatic wait_round(input logic [3:0] r);
    for (int i = 0; i < 200 && !(rk_valid && rk_round == r); i++) tick();
    check("reach_round", {123'(0), rk_valid, rk_round}, {123'(0), 1'b1, r});
  endtask

  task automatic check_idle_after_reset(input string tag);
    check({tag, "_rk_valid"}, 128'(rk_valid), 128'(0));
    check({tag, "_cache_vld"}, 128'(cache_vld), 128'(0));
    check({tag, "_key_ready"}, 128'(key_ready), 128'(1));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_rk_out"}, rk_out, 128'(0));
  endtask

  initial begin
    int lat;
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check_idle_after_reset("reset");
    check("reset_rk_round", 128'(rk_round), 128'(0));
    check("reset_rk_last", 128'(rk_last), 128'(0));

    // 1: load FIPS key with rk_ready high
    push_stream1();
    load_key(RK_TAB[0]);
    measure_latency(lat);
    check("load_latency", 128'(lat), 128'(11));
    wait_idle("t1_idle", 100);
    check("t1_drained", 128'(q1.size()), 128'(0));
    check("t1_cache_vld", 128'(cache_vld), 128'(1));
    check("t1_key_ready", 128'(key_ready), 128'(1));

    // 3: replay from cache, no forward phase
    push_stream1();
    pulse_replay();
    check("replay_valid", 128'(rk_valid), 128'(1));
    check("replay_round", 128'(rk_round), 128'(10));
    wait_idle("t3_idle", 100);
    check("t3_drained", 128'(q1.size()), 128'(0));

    // 2: random back-pressure
    push_stream1();
    rand_ready = 1'b1;
    load_key(RK_TAB[0]);
    wait_idle("t2_idle", 600);
    rand_ready = 1'b0;
    rk_ready = 1'b1;
    check("t2_drained", 128'(q1.size()), 128'(0));

    // 4: key_valid and replay mid-stream are ignored
    push_stream1();
    pulse_replay();
    wait_round(4'd6);
    key_in    = '1;
    key_valid = 1'b1;
    replay    = 1'b1;
    tick();
    tick();
    key_valid = 1'b0;
    replay    = 1'b0;
    wait_idle("t4_idle", 100);
    check("t4_drained", 128'(q1.size()), 128'(0));
    check("t4_cache_vld", 128'(cache_vld), 128'(1));
    push_stream1();
    pulse_replay();
    wait_idle("t4_replay_idle", 100);
    check("t4_replay_drained", 128'(q1.size()), 128'(0));

    // key_valid wins over replay in IDLE: full forward phase follows
    push_stream1();
    key_in    = RK_TAB[0];
    key_valid = 1'b1;
    replay    = 1'b1;
    tick();
    key_valid = 1'b0;
    replay    = 1'b0;
    check("kv_wins_cache_cleared", 128'(cache_vld), 128'(0));
    measure_latency(lat);
    check("kv_wins_latency", 128'(lat), 128'(11));
    wait_idle("kv_wins_idle", 100);

    // replay with empty cache does nothing
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_cache_vld", 128'(cache_vld), 128'(0));
    replay = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("nocache_rk_valid", 128'(rk_valid), 128'(0));
      check("nocache_busy", 128'(busy), 128'(0));
    end
    replay = 1'b0;

    // 5a: reset during forward step 5
    load_key(RK_TAB[0]);
    repeat (5) tick();
    check("fwd_busy_before_rst", 128'(busy), 128'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_after_reset("rst_fwd");

    // 5b: reset while round 4 is presented
    push_stream1();
    load_key(RK_TAB[0]);
    wait_round(4'd4);
    rk_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q1.delete();
    check_idle_after_reset("rst_rev");
    rk_ready = 1'b1;
    repeat (3) tick();
    check("rst_rev_quiet", 128'(rk_valid), 128'(0));

    // 6: KEY_IS_LAST instance loads round key 10 directly
    push_stream2();
    key_in2    = RK_TAB[10];
    key_valid2 = 1'b1;
    tick();
    key_valid2 = 1'b0;
    check("last_valid", 128'(rk_valid2), 128'(1));
    check("last_round", 128'(rk_round2), 128'(10));
    check("last_cache_vld", 128'(cache_vld2), 128'(1));
    for (int i = 0; i < 100 && busy2; i++) tick();
    check("last_idle", 128'(busy2), 128'(0));
    check("last_drained", 128'(q2.size()), 128'(0));
    check("last_final_rk", rk_out2, RK_TAB[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
